// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// state codes, opcode values, ALU/mux encodings and the control-word struct.
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC   = 4'd2;
  localparam logic [3:0] ST_ALUWB  = 4'd3;
  localparam logic [3:0] ST_ADDIEX = 4'd4;
  localparam logic [3:0] ST_ADDIWB = 4'd5;
  localparam logic [3:0] ST_MEMADR = 4'd6;
  localparam logic [3:0] ST_MEMRD  = 4'd7;
  localparam logic [3:0] ST_MEMWB  = 4'd8;
  localparam logic [3:0] ST_MEMWR  = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  typedef enum logic [3:0] {
    FETCH  = ST_FETCH,
    DECODE = ST_DECODE,
    EXEC   = ST_EXEC,
    ALUWB  = ST_ALUWB,
    ADDIEX = ST_ADDIEX,
    ADDIWB = ST_ADDIWB,
    MEMADR = ST_MEMADR,
    MEMRD  = ST_MEMRD,
    MEMWB  = ST_MEMWB,
    MEMWR  = ST_MEMWR,
    BRANCH = ST_BRANCH,
    JUMP   = ST_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       branchne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       extop;
    logic       instrdone;
  } ctrl_t;

  typedef struct packed {
    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_br;
    logic is_j;
    logic is_illegal;
  } op_class_t;

  // States that talk to memory and therefore wait on MemReady.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier; bits above the 6 defined opcode bits
// must be zero for any legal match.
module mc_opcode_class
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls
);

  logic [5:0] op6;
  logic       upper_zero;

  generate
    if (OPCODE_W > 6) begin : g_wide
      assign op6        = opcode[5:0];
      assign upper_zero = ~|opcode[OPCODE_W-1:6];
    end else if (OPCODE_W == 6) begin : g_exact
      assign op6        = opcode;
      assign upper_zero = 1'b1;
    end else begin : g_narrow
      assign op6        = {{(6 - OPCODE_W){1'b0}}, opcode};
      assign upper_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    cls = '0;
    if (upper_zero) begin
      case (op6)
        OP_RTYPE:       cls.is_r    = 1'b1;
        OP_ADDI:        cls.is_addi = 1'b1;
        OP_LW:          cls.is_lw   = 1'b1;
        OP_SW:          cls.is_sw   = 1'b1;
        OP_BEQ, OP_BNE: cls.is_br   = 1'b1;
        OP_J:           cls.is_j    = 1'b1;
        default:        cls.is_illegal = 1'b1;
      endcase
    end else begin
      cls.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes, with MemReady wait states in memory states.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchNe,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [1:0]          PCSource,
  output logic                Extop,
  output logic                InstrDone,
  output logic                IllegalOp,
  output logic [3:0]          State
);

  state_t    state_reg, state_next;
  logic      illegal_reg, illegal_next;
  op_class_t cls;
  ctrl_t     ctrl, ctrl_out;
  logic      mem_ready;

  assign mem_ready = MEM_WAIT ? MemReady : 1'b1;

  mc_opcode_class #(
    .OPCODE_W(OPCODE_W)
  ) u_class (
    .opcode(Opcode),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    ctrl         = '0;
    case (state_reg)
      FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALU_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite  = mem_ready;
        ctrl.irwrite  = mem_ready;
        state_next    = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is examined
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALU_ADD;
        ctrl.extop   = 1'b1;
        if (cls.is_illegal) begin
          illegal_next   = 1'b1;
          ctrl.instrdone = 1'b1;
          state_next     = FETCH;
        end else if (cls.is_r) begin
          state_next = EXEC;
        end else if (cls.is_addi) begin
          state_next = ADDIEX;
        end else if (cls.is_lw || cls.is_sw) begin
          state_next = MEMADR;
        end else if (cls.is_br) begin
          state_next = BRANCH;
        end else begin
          state_next = JUMP;
        end
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
        state_next   = ALUWB;
      end
      ALUWB: begin
        ctrl.regdst    = 1'b1;
        ctrl.regwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
        state_next     = FETCH;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
        ctrl.extop   = 1'b1;
        state_next   = ADDIWB;
      end
      ADDIWB: begin
        ctrl.regwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
        state_next     = FETCH;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
        ctrl.extop   = 1'b1;
        if (cls.is_lw)      state_next = MEMRD;
        else if (cls.is_sw) state_next = MEMWR;
        else                state_next = FETCH;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        state_next   = MEMWB;
      end
      MEMWB: begin
        ctrl.memtoreg  = 1'b1;
        ctrl.regwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
        state_next     = FETCH;
      end
      MEMWR: begin
        ctrl.memwrite  = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.instrdone = mem_ready;
        state_next     = FETCH;
      end
      BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_B;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.branchne    = Opcode[0];
        ctrl.instrdone   = 1'b1;
        state_next       = FETCH;
      end
      JUMP: begin
        ctrl.pcwrite   = 1'b1;
        ctrl.pcsource  = PCSRC_JUMP;
        ctrl.instrdone = 1'b1;
        state_next     = FETCH;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
    // A memory state without MemReady holds, keeping its request asserted
    if (is_mem_state(state_reg) && !mem_ready) begin
      state_next = state_reg;
    end
  end

  // Reset blanks every strobe at once so an aborted instruction writes nothing
  assign ctrl_out = reset ? '0 : ctrl;

  assign PCWrite     = ctrl_out.pcwrite;
  assign PCWriteCond = ctrl_out.pcwritecond;
  assign BranchNe    = ctrl_out.branchne;
  assign IorD        = ctrl_out.iord;
  assign MemRead     = ctrl_out.memread;
  assign MemWrite    = ctrl_out.memwrite;
  assign IRWrite     = ctrl_out.irwrite;
  assign RegDst      = ctrl_out.regdst;
  assign MemtoReg    = ctrl_out.memtoreg;
  assign RegWrite    = ctrl_out.regwrite;
  assign ALUSrcA     = ctrl_out.alusrca;
  assign ALUSrcB     = ctrl_out.alusrcb;
  assign ALUop       = ALUOP_W'(ctrl_out.aluop);
  assign PCSource    = ctrl_out.pcsource;
  assign Extop       = ctrl_out.extop;
  assign InstrDone   = ctrl_out.instrdone;
  assign IllegalOp   = illegal_reg;
  assign State       = reset ? ST_FETCH : state_reg;

endmodule
